// File: rtl/linescanner_line_assembler_pkg.sv
// Shared types and constants for the line-scanner line assembler.
package linescanner_line_assembler_pkg;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_CAPTURE = 2'd1,
    W_SKIP    = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

  localparam int DROPPED_COUNT_WIDTH = 16;

endpackage

// File: rtl/linescanner_line_buffer_ram.sv
// Two-bank line buffer: simple dual-port RAM, bank bit is the address MSB,
// synchronous read with one cycle of latency.
module linescanner_line_buffer_ram #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH:0]    wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH:0]    rd_addr,
  output logic [PIXEL_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

  logic [PIXEL_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/linescanner_line_assembler.sv
// Assembles lval-framed lines into a ping-pong buffer and streams each
// completed line out over valid/ready with an end-of-line marker.
module linescanner_line_assembler
  import linescanner_line_assembler_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 8,
  parameter int MAX_LINE_PIXELS = 1024,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                           pixel_clock,
  input  logic                           n_reset,
  input  logic                           enable,
  input  logic                           lval,
  input  logic [PIXEL_WIDTH-1:0]         pixel_data,
  output logic [PIXEL_WIDTH-1:0]         out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [ADDR_WIDTH:0]            out_line_length,
  output logic                           line_truncated,
  output logic                           line_dropped,
  output logic [DROPPED_COUNT_WIDTH-1:0] dropped_count
);

  // Handshake: a pixel transfers on a rising edge where out_valid && out_ready;
  // once out_valid is high, out_data/out_last hold until that transfer.

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(MAX_LINE_PIXELS);
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic                   lval_q;
  logic [ADDR_WIDTH:0]    wr_count;
  logic                   wr_trunc;
  logic                   wr_bank;
  logic                   rd_bank;
  logic [1:0]             bank_full;
  logic [ADDR_WIDTH:0]    bank_len [2];
  logic                   bank_trunc [2];

  logic [ADDR_WIDTH:0]    issue_cnt;
  logic                   pending;
  logic                   pending_last;
  logic                   skid_valid;
  logic                   skid_last;
  logic [PIXEL_WIDTH-1:0] skid_data;

  logic                   line_start;
  logic                   line_end;
  logic                   commit;
  logic                   ram_we;
  logic [ADDR_WIDTH:0]    ram_waddr;
  logic                   ram_re;
  logic [ADDR_WIDTH:0]    ram_raddr;
  logic [PIXEL_WIDTH-1:0] ram_rdata;

  logic                   pop;
  logic                   rd_release;
  logic                   start_read;
  logic                   next_bank;
  logic                   stream_issue;
  logic                   issue_last;
  logic [1:0]             occ;

  always_comb begin
    line_start = lval & ~lval_q;
    line_end   = ~lval & lval_q;
    commit     = (wr_state == W_CAPTURE) && line_end;
    ram_we     = ((wr_state == W_IDLE) && line_start && enable && !bank_full[wr_bank]) ||
                 ((wr_state == W_CAPTURE) && lval && (wr_count < MAX_COUNT));
    ram_waddr  = {wr_bank, (wr_state == W_CAPTURE) ? wr_count[ADDR_WIDTH-1:0]
                                                   : {ADDR_WIDTH{1'b0}}};
  end

  // Reads are issued only while fewer than two pixels are held or in flight,
  // so the output and skid registers can never overflow under back-pressure.
  always_comb begin
    pop          = out_valid & out_ready;
    rd_release   = pop & out_last;
    occ          = 2'(out_valid) + 2'(skid_valid) + 2'(pending) - 2'(pop);
    start_read   = ((rd_state == R_IDLE) && bank_full[rd_bank]) ||
                   ((rd_state == R_STREAM) && rd_release && bank_full[~rd_bank]);
    next_bank    = (rd_state == R_IDLE) ? rd_bank : ~rd_bank;
    stream_issue = (rd_state == R_STREAM) && !rd_release &&
                   (issue_cnt < out_line_length) && (occ < 2'd2);
    ram_re       = start_read | stream_issue;
    ram_raddr    = start_read ? {next_bank, {ADDR_WIDTH{1'b0}}}
                              : {rd_bank, issue_cnt[ADDR_WIDTH-1:0]};
    issue_last   = start_read ? (bank_len[next_bank] == ONE)
                              : (issue_cnt == out_line_length - ONE);
  end

  linescanner_line_buffer_ram #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_ram (
    .clk     (pixel_clock),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (pixel_data),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // Commit and release always target different banks, so both may land together.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      bank_full <= 2'b00;
    end else begin
      if (commit)     bank_full[wr_bank] <= 1'b1;
      if (rd_release) bank_full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      wr_state      <= W_IDLE;
      lval_q        <= 1'b0;
      wr_count      <= '0;
      wr_trunc      <= 1'b0;
      wr_bank       <= 1'b0;
      bank_len[0]   <= '0;
      bank_len[1]   <= '0;
      bank_trunc[0] <= 1'b0;
      bank_trunc[1] <= 1'b0;
      line_dropped  <= 1'b0;
      dropped_count <= '0;
    end else begin
      lval_q       <= lval;
      line_dropped <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (line_start) begin
            if (!enable) begin
              wr_state <= W_SKIP;
            end else if (!bank_full[wr_bank]) begin
              wr_count <= ONE;
              wr_trunc <= 1'b0;
              wr_state <= W_CAPTURE;
            end else begin
              line_dropped <= 1'b1;
              if (dropped_count != {DROPPED_COUNT_WIDTH{1'b1}})
                dropped_count <= dropped_count + DROPPED_COUNT_WIDTH'(1);
              wr_state <= W_SKIP;
            end
          end
        end
        W_CAPTURE: begin
          if (lval) begin
            if (wr_count < MAX_COUNT) wr_count <= wr_count + ONE;
            else                      wr_trunc <= 1'b1;
          end else begin
            bank_len[wr_bank]   <= wr_count;
            bank_trunc[wr_bank] <= wr_trunc;
            wr_bank             <= ~wr_bank;
            wr_state            <= W_IDLE;
          end
        end
        W_SKIP: begin
          if (line_end) wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      rd_state        <= R_IDLE;
      rd_bank         <= 1'b0;
      issue_cnt       <= '0;
      pending         <= 1'b0;
      pending_last    <= 1'b0;
      skid_valid      <= 1'b0;
      skid_last       <= 1'b0;
      skid_data       <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      out_data        <= '0;
      out_line_length <= '0;
      line_truncated  <= 1'b0;
    end else begin
      if (start_read) begin
        rd_state        <= R_STREAM;
        rd_bank         <= next_bank;
        out_line_length <= bank_len[next_bank];
        line_truncated  <= bank_trunc[next_bank];
        issue_cnt       <= ONE;
      end else if (rd_release) begin
        rd_state <= R_IDLE;
        rd_bank  <= ~rd_bank;
      end else if (stream_issue) begin
        issue_cnt <= issue_cnt + ONE;
      end
      pending      <= ram_re;
      pending_last <= issue_last;

      // Output stage refills from the skid register first to keep order.
      if (!out_valid || pop) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_last   <= skid_last;
          out_valid  <= 1'b1;
          skid_valid <= pending;
          if (pending) begin
            skid_data <= ram_rdata;
            skid_last <= pending_last;
          end
        end else if (pending) begin
          out_data  <= ram_rdata;
          out_last  <= pending_last;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (pending) begin
        skid_data  <= ram_rdata;
        skid_last  <= pending_last;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_linescanner_line_assembler.sv
// Directed bench for the line assembler, built with an 8-pixel line buffer.
module tb_linescanner_line_assembler;

  localparam int PW   = 8;
  localparam int MAXP = 8;
  localparam int AW   = 3;
  localparam int EW   = 1 + (AW + 1) + 1 + PW;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          enable;
  logic          lval;
  logic [PW-1:0] pixel_data;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [AW:0]   out_line_length;
  logic          line_truncated;
  logic          line_dropped;
  logic [15:0]   dropped_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  logic          stall_q = 1'b0;
  logic [PW:0]   stall_word;

  always #5 clk = ~clk;

  linescanner_line_assembler #(
    .PIXEL_WIDTH     (PW),
    .MAX_LINE_PIXELS (MAXP),
    .ADDR_WIDTH      (AW)
  ) dut (
    .pixel_clock     (clk),
    .n_reset         (n_reset),
    .enable          (enable),
    .lval            (lval),
    .pixel_data      (pixel_data),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .out_line_length (out_line_length),
    .line_truncated  (line_truncated),
    .line_dropped    (line_dropped),
    .dropped_count   (dropped_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [EW-1:0] ent(input logic t, input logic [AW:0] len,
                                        input logic last, input logic [PW-1:0] d);
    return {t, len, last, d};
  endfunction

  // Monitor: record every accepted pixel and check outputs hold during stalls.
  always @(negedge clk) begin
    if (stall_q) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'({out_last, out_data}), 32'(stall_word));
    end
    stall_q    = n_reset && out_valid && !out_ready;
    stall_word = {out_last, out_data};
    if (n_reset && out_valid && out_ready)
      obs_q.push_back(ent(line_truncated, out_line_length, out_last, out_data));
  end

  task automatic send_line(input int n, input logic [PW-1:0] base,
                           input logic exp_drop, input int en_idx);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("drop_pulse", 32'(line_dropped), 32'(exp_drop));
      if (i == en_idx) enable = 1'b1;
      lval       = 1'b1;
      pixel_data = base + PW'(i);
    end
    @(posedge clk); #1;
    lval = 1'b0;
  endtask

  task automatic push_line(input int n, input logic [PW-1:0] base,
                           input logic [AW:0] len, input logic trunc);
    for (int i = 0; i < n; i++)
      exp_q.push_back(ent(trunc, len, i == n - 1, base + PW'(i)));
  endtask

  task automatic drain_check(input string tag);
    int waited = 0;
    while (obs_q.size() < exp_q.size() && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    repeat (10) @(posedge clk);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},   32'(out_valid), 32'd0);
    check({tag, "_last"},    32'(out_last), 32'd0);
    check({tag, "_data"},    32'(out_data), 32'd0);
    check({tag, "_len"},     32'(out_line_length), 32'd0);
    check({tag, "_trunc"},   32'(line_truncated), 32'd0);
    check({tag, "_dpulse"},  32'(line_dropped), 32'd0);
    check({tag, "_dcount"},  32'(dropped_count), 32'd0);
  endtask

  logic [3:0] rdy_pat = 4'b1001;
  bit         rdy_done;
  int         waited;

  initial begin
    n_reset    = 1'b0;
    enable     = 1'b1;
    lval       = 1'b0;
    pixel_data = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    n_reset = 1'b1;
    repeat (2) @(posedge clk);

    // 5-pixel line, ready high: latency and back-to-back delivery.
    send_line(5, 8'h10, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("burst_valid", 32'(out_valid), 32'd1);
      check("burst_data", 32'(out_data), 32'h10 + 32'(i));
      check("burst_last", 32'(out_last), 32'(i == 4));
      check("burst_len", 32'(out_line_length), 32'd5);
    end
    push_line(5, 8'h10, 4'd5, 1'b0);
    drain_check("line5");

    // Same line with ready toggling 1,0,0,1.
    rdy_done = 1'b0;
    fork
      begin
        send_line(5, 8'h10, 1'b0, 0);
        repeat (30) @(posedge clk);
        rdy_done = 1'b1;
      end
      begin
        for (int k = 0; !rdy_done && k < 200; k++) begin
          @(posedge clk); #1;
          out_ready = rdy_pat[k % 4];
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_line(5, 8'h10, 4'd5, 1'b0);
    drain_check("toggle");

    // Ready low, three lines: third is dropped.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_line(4, 8'h20, 1'b0, 0);
    send_line(4, 8'h30, 1'b0, 0);
    send_line(4, 8'h40, 1'b1, 0);
    @(posedge clk); #1;
    check("drop_count", 32'(dropped_count), 32'd1);
    check("drop_pulse_end", 32'(line_dropped), 32'd0);
    out_ready = 1'b1;
    push_line(4, 8'h20, 4'd4, 1'b0);
    push_line(4, 8'h30, 4'd4, 1'b0);
    drain_check("fifo");

    // 11-pixel line into an 8-pixel buffer.
    send_line(11, 8'h50, 1'b0, 0);
    push_line(8, 8'h50, 4'd8, 1'b1);
    drain_check("trunc");

    // Line started with enable low is skipped even if enable rises mid-line.
    @(posedge clk); #1;
    enable = 1'b0;
    send_line(4, 8'h58, 1'b0, 2);
    drain_check("skip");
    check("skip_dcount", 32'(dropped_count), 32'd1);
    send_line(3, 8'h60, 1'b0, 0);
    push_line(3, 8'h60, 4'd3, 1'b0);
    drain_check("after_skip");

    // Asynchronous reset mid-stream.
    send_line(6, 8'h70, 1'b0, 0);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #3;
    n_reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk); #1;
    n_reset = 1'b1;
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    send_line(2, 8'h80, 1'b0, 0);
    push_line(2, 8'h80, 4'd2, 1'b0);
    drain_check("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
